// File: rtl/mips32_pipe_core_if.sv
// ---------------------------------------------------------------------------
// mips32_pipe_core_if
// Status bundle of the 5-stage MIPS32-subset core.
//   halted  : HLT has retired, core frozen until reset
//   pc_out  : current fetch PC (word index)
//   retired : saturating count of retired instructions
// Modports: master (driven by the core), slave (observers / bench).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface mips32_pipe_core_if #(
   parameter int CNT_W = 32
);
   logic             halted;
   logic [31:0]      pc_out;
   logic [CNT_W-1:0] retired;

   modport master (output halted, output pc_out, output retired);
   modport slave  (input  halted, input  pc_out, input  retired);
endinterface

// File: rtl/mips32_pipe_core.sv
// ---------------------------------------------------------------------------
// mips32_pipe_core
// Single-clock IF/ID/EX/MEM/WB MIPS32-subset core with RAW interlock,
// branch squash (resolved in EX), halt freeze and a retire counter.
// Unified word-addressed instruction/data array Mem[] and register file
// Reg[] are plain arrays (not reset) so they can be preloaded.
// Ports:
//   clk    : clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : mips32_pipe_core_if.master (halted, pc_out, retired)
// Build option: define MIPS32_FWD_EN for EX operand forwarding (only
// load-use stalls); otherwise ID interlocks until the producer reaches WB.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module mips32_pipe_core #(
   parameter int          MEM_DEPTH = 1024,
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter int          CNT_W     = 32
) (
   input  logic clk,
   input  logic rst_n,
   mips32_pipe_core_if.master bus
);
   localparam int AW = $clog2(MEM_DEPTH);
   localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_AND  = 6'b000010,
                          OP_OR   = 6'b000011, OP_SLT  = 6'b000100, OP_MUL  = 6'b000101,
                          OP_LW   = 6'b001000, OP_SW   = 6'b001001, OP_ADDI = 6'b001010,
                          OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101,
                          OP_BEQZ = 6'b001110, OP_HLT  = 6'b111111;

   logic [31:0] Mem [MEM_DEPTH];
   logic [31:0] Reg [32];

   function automatic logic is_legal(input logic [5:0] op);
      return (op <= OP_MUL) || (op >= OP_LW && op <= OP_BEQZ) || (op == OP_HLT);
   endfunction

   // Destination actually written; 0 for non-writers (R0 writes are discarded anyway)
   function automatic logic [4:0] edest(input logic [31:0] ir);
      if (ir[31:26] <= OP_MUL) return ir[15:11];
      else if (ir[31:26] == OP_LW || ir[31:26] == OP_ADDI ||
               ir[31:26] == OP_SUBI || ir[31:26] == OP_SLTI) return ir[20:16];
      else return 5'd0;
   endfunction

   // True when instruction ir reads register d (d != 0) as a source
   function automatic logic dep(input logic [4:0] d, input logic [31:0] ir);
      logic uses_rt;
      uses_rt = (ir[31:26] <= OP_MUL) || (ir[31:26] == OP_SW) ||
                (ir[31:26] == OP_BNEQZ) || (ir[31:26] == OP_BEQZ);
      return (d != 5'd0) && (ir[31:26] != OP_HLT) &&
             ((d == ir[25:21]) || (uses_rt && d == ir[20:16]));
   endfunction

   // Youngest-first operand select: EX/MEM ALU result, then MEM/WB result
   function automatic logic [31:0] fwd_sel(input logic [4:0] r, input logic [31:0] base,
                                           input logic [4:0] md, input logic md_ok,
                                           input logic [31:0] mv, input logic [4:0] wd,
                                           input logic [31:0] wv);
      if (r != 5'd0 && md_ok && md == r) return mv;
      else if (r != 5'd0 && wd == r) return wv;
      else return base;
   endfunction

   logic        ifid_v_r, idex_v_r, exmem_v_r, memwb_v_r;
   logic [31:0] ifid_ir_r, ifid_pc_r, idex_ir_r, idex_pc_r, idex_a_r, idex_b_r;
   logic [31:0] exmem_ir_r, exmem_alu_r, exmem_b_r, memwb_ir_r, memwb_alu_r, memwb_lmd_r;
   logic [31:0] pc_r;
   logic        stop_r, halted_r;
   logic [CNT_W-1:0] retired_r;

   logic [4:0]  ex_dest_s, mem_dest_s, wb_dest_s;
   logic [31:0] wb_val_s, rd_a_s, rd_b_s, ex_a_s, ex_b_s, ex_imm_s, ex_alu_s, target_s;
   logic        id_valid_s, hlt_id_s, stall_s, taken_s;
   logic [AW-1:0] mem_addr_s;

   assign ex_dest_s  = idex_v_r  ? edest(idex_ir_r)  : 5'd0;
   assign mem_dest_s = exmem_v_r ? edest(exmem_ir_r) : 5'd0;
   assign wb_dest_s  = memwb_v_r ? edest(memwb_ir_r) : 5'd0;
   assign wb_val_s   = (memwb_ir_r[31:26] == OP_LW) ? memwb_lmd_r : memwb_alu_r;
   assign id_valid_s = ifid_v_r && is_legal(ifid_ir_r[31:26]);
   assign hlt_id_s   = id_valid_s && (ifid_ir_r[31:26] == OP_HLT);
   assign ex_imm_s   = {{16{idex_ir_r[15]}}, idex_ir_r[15:0]};
   assign target_s   = idex_pc_r + 32'd1 + ex_imm_s;
   assign mem_addr_s = exmem_alu_r[AW-1:0];

   // ID register read with write-through from the instruction leaving WB
   always_comb begin
      rd_a_s = 32'd0;
      rd_b_s = 32'd0;
      if (ifid_ir_r[25:21] == 5'd0) rd_a_s = 32'd0;
      else if (ifid_ir_r[25:21] == wb_dest_s) rd_a_s = wb_val_s;
      else rd_a_s = Reg[ifid_ir_r[25:21]];
      if (ifid_ir_r[20:16] == 5'd0) rd_b_s = 32'd0;
      else if (ifid_ir_r[20:16] == wb_dest_s) rd_b_s = wb_val_s;
      else rd_b_s = Reg[ifid_ir_r[20:16]];
   end

   // RAW interlock and EX operand selection
   always_comb begin
`ifdef MIPS32_FWD_EN
      stall_s = id_valid_s && idex_v_r && (idex_ir_r[31:26] == OP_LW) && dep(ex_dest_s, ifid_ir_r);
      ex_a_s  = fwd_sel(idex_ir_r[25:21], idex_a_r, mem_dest_s, exmem_ir_r[31:26] != OP_LW,
                        exmem_alu_r, wb_dest_s, wb_val_s);
      ex_b_s  = fwd_sel(idex_ir_r[20:16], idex_b_r, mem_dest_s, exmem_ir_r[31:26] != OP_LW,
                        exmem_alu_r, wb_dest_s, wb_val_s);
`else
      stall_s = id_valid_s && (dep(ex_dest_s, ifid_ir_r) || dep(mem_dest_s, ifid_ir_r));
      ex_a_s  = idex_a_r;
      ex_b_s  = idex_b_r;
`endif
   end

   // EX stage ALU and branch resolution
   always_comb begin
      ex_alu_s = 32'd0;
      taken_s  = 1'b0;
      case (idex_ir_r[31:26])
         OP_ADD:  ex_alu_s = ex_a_s + ex_b_s;
         OP_SUB:  ex_alu_s = ex_a_s - ex_b_s;
         OP_AND:  ex_alu_s = ex_a_s & ex_b_s;
         OP_OR:   ex_alu_s = ex_a_s | ex_b_s;
         OP_SLT:  ex_alu_s = {31'd0, $signed(ex_a_s) < $signed(ex_b_s)};
         OP_MUL:  ex_alu_s = ex_a_s * ex_b_s;
         OP_LW, OP_SW, OP_ADDI: ex_alu_s = ex_a_s + ex_imm_s;
         OP_SUBI: ex_alu_s = ex_a_s - ex_imm_s;
         OP_SLTI: ex_alu_s = {31'd0, $signed(ex_a_s) < $signed(ex_imm_s)};
         OP_BNEQZ: taken_s = idex_v_r && (ex_a_s != 32'd0);
         OP_BEQZ:  taken_s = idex_v_r && (ex_a_s == 32'd0);
         default: ex_alu_s = 32'd0;
      endcase
   end

   // Pipeline latches, PC, halt and retire counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_PC;   stop_r <= 1'b0;   halted_r <= 1'b0;   retired_r <= '0;
         ifid_v_r <= 1'b0;   ifid_ir_r <= 32'd0;   ifid_pc_r <= 32'd0;
         idex_v_r <= 1'b0;   idex_ir_r <= 32'd0;   idex_pc_r <= 32'd0;
         idex_a_r <= 32'd0;  idex_b_r <= 32'd0;
         exmem_v_r <= 1'b0;  exmem_ir_r <= 32'd0;  exmem_alu_r <= 32'd0;  exmem_b_r <= 32'd0;
         memwb_v_r <= 1'b0;  memwb_ir_r <= 32'd0;  memwb_alu_r <= 32'd0;  memwb_lmd_r <= 32'd0;
      end else if (!halted_r) begin
         memwb_v_r   <= exmem_v_r;
         memwb_ir_r  <= exmem_ir_r;
         memwb_alu_r <= exmem_alu_r;
         memwb_lmd_r <= Mem[mem_addr_s];
         exmem_v_r   <= idex_v_r;
         exmem_ir_r  <= idex_ir_r;
         exmem_alu_r <= ex_alu_s;
         exmem_b_r   <= ex_b_s;
         // Squash or stall inject a bubble into EX; illegal opcodes enter as bubbles
         idex_v_r  <= id_valid_s && !taken_s && !stall_s;
         idex_ir_r <= ifid_ir_r;
         idex_pc_r <= ifid_pc_r;
         idex_a_r  <= rd_a_s;
         idex_b_r  <= rd_b_s;
         if (taken_s) begin
            ifid_v_r <= 1'b0;
            pc_r     <= target_s;
         end else if (stall_s) begin
            ifid_v_r <= ifid_v_r;
         end else if (stop_r || hlt_id_s) begin
            ifid_v_r <= 1'b0;
         end else begin
            ifid_v_r  <= 1'b1;
            ifid_ir_r <= Mem[pc_r[AW-1:0]];
            ifid_pc_r <= pc_r;
            pc_r      <= pc_r + 32'd1;
         end
         if (hlt_id_s && !taken_s) stop_r <= 1'b1;
         if (memwb_v_r) begin
            if (memwb_ir_r[31:26] == OP_HLT) halted_r <= 1'b1;
            if (retired_r != {CNT_W{1'b1}}) retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Architectural writes: store in MEM, register write in WB (R0 never written)
   always_ff @(posedge clk) begin
      if (!halted_r && exmem_v_r && exmem_ir_r[31:26] == OP_SW) Mem[mem_addr_s] <= exmem_b_r;
      if (!halted_r && wb_dest_s != 5'd0) Reg[wb_dest_s] <= wb_val_s;
   end

   assign bus.halted  = halted_r;
   assign bus.pc_out  = pc_r;
   assign bus.retired = retired_r;
endmodule

// File: tb/tb_mips32_pipe_core.sv
`timescale 1ns/1ps
module tb_mips32_pipe_core;
   localparam int CNT_W = 32;
   localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011,
                          SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001,
                          ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100,
                          BNEQZ = 6'b001101, BEQZ = 6'b001110;
   localparam logic [31:0] HLT = 32'hFC000000;
   localparam logic [31:0] NOPW = 32'h54000000;  // opcode 010101

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   mips32_pipe_core_if #(.CNT_W(CNT_W)) bus ();
   mips32_pipe_core #(.MEM_DEPTH(1024), .RESET_PC(32'd0), .CNT_W(CNT_W))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0][31:0] prog;
      int          n;
      logic [4:0]  pre_r;  logic [31:0] pre_rv;
      logic [9:0]  pre_m;  logic [31:0] pre_mv;
      logic [4:0]  ra;     logic [31:0] va;
      logic [4:0]  rb;     logic [31:0] vb;
      logic [9:0]  cm;     logic [31:0] cmv;
      int          cyc_fwd, cyc_nofwd, ret;
   } vec_t;
   vec_t vecs[7];
   logic [31:0] hp[$];

   function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {op, rs, rt, rd, 11'd0};
   endfunction
   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input int imm);
      return {op, rs, rt, imm[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
      end
   endtask

   task automatic enter_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check({tag, "_rst_pc"}, bus.pc_out, 32'd0);
      check({tag, "_rst_halted"}, {31'd0, bus.halted}, 32'd0);
      check({tag, "_rst_retired"}, bus.retired, 32'd0);
   endtask

   task automatic clear_state();
      for (int i = 0; i < 1024; i++) dut.Mem[i] <= 32'd0;
      for (int i = 0; i < 32; i++) dut.Reg[i] <= 32'd0;
   endtask

   task automatic load_hp();
      for (int k = 0; k < hp.size(); k++) dut.Mem[k] <= hp[k];
   endtask

   task automatic run_to_halt(input string tag, input int budget, output int cyc);
      bit done;
      done = 1'b0;
      cyc = 0;
      @(negedge clk);
      rst_n = 1'b1;
      while (!done && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.halted) done = 1'b1;
      end
      check({tag, "_halt_reached"}, {31'd0, done}, 32'd1);
   endtask

   task automatic load_factorial();
      hp = '{enc_i(ADDI, 0, 10, 200), enc_i(ADDI, 0, 2, 1), enc_i(LW, 10, 3, 0),
             enc_r(MUL, 2, 3, 2), enc_i(SUBI, 3, 3, 1), enc_i(BNEQZ, 3, 0, -3),
             enc_i(SW, 10, 2, -2), HLT};
      load_hp();
      dut.Mem[200] <= 32'd7;
   endtask

   int cyc;
   int exp_cyc;

   initial begin
      // ---- vector table ----
      for (int t = 0; t < 7; t++) begin
         vecs[t].prog = '0;    vecs[t].pre_r = 5'd0;   vecs[t].pre_rv = 32'd0;
         vecs[t].pre_m = 10'd900; vecs[t].pre_mv = 32'd0;
         vecs[t].cm = 10'd50;  vecs[t].cmv = 32'd0;
      end
      // RAW chain
      vecs[0].prog[0] = enc_i(ADDI, 0, 1, 5); vecs[0].prog[1] = enc_r(ADD, 1, 1, 2);
      vecs[0].prog[2] = enc_r(ADD, 2, 1, 3);  vecs[0].prog[3] = HLT; vecs[0].n = 4;
      vecs[0].ra = 5'd3; vecs[0].va = 32'd15; vecs[0].rb = 5'd2; vecs[0].vb = 32'd10;
      vecs[0].cyc_fwd = 8; vecs[0].cyc_nofwd = 12; vecs[0].ret = 4;
      // load-use
      vecs[1].prog[0] = enc_i(LW, 10, 4, 0); vecs[1].prog[1] = enc_r(ADD, 4, 4, 5);
      vecs[1].prog[2] = HLT; vecs[1].n = 3;
      vecs[1].pre_r = 5'd10; vecs[1].pre_rv = 32'd120; vecs[1].pre_m = 10'd120; vecs[1].pre_mv = 32'd9;
      vecs[1].ra = 5'd5; vecs[1].va = 32'd18; vecs[1].rb = 5'd4; vecs[1].vb = 32'd9;
      vecs[1].cm = 10'd120; vecs[1].cmv = 32'd9;
      vecs[1].cyc_fwd = 8; vecs[1].cyc_nofwd = 9; vecs[1].ret = 3;
      // R0 write discard and illegal opcode as NOP
      vecs[2].prog[0] = enc_i(ADDI, 0, 0, 7); vecs[2].prog[1] = NOPW;
      vecs[2].prog[2] = enc_r(ADD, 0, 0, 1);  vecs[2].prog[3] = HLT; vecs[2].n = 4;
      vecs[2].pre_r = 5'd1; vecs[2].pre_rv = 32'd99;
      vecs[2].ra = 5'd1; vecs[2].va = 32'd0; vecs[2].rb = 5'd0; vecs[2].vb = 32'd0;
      vecs[2].cyc_fwd = 8; vecs[2].cyc_nofwd = 8; vecs[2].ret = 3;
      // branch not taken
      vecs[3].prog[0] = enc_i(BNEQZ, 0, 0, 5); vecs[3].prog[1] = enc_i(ADDI, 0, 6, 4);
      vecs[3].prog[2] = HLT; vecs[3].n = 3;
      vecs[3].ra = 5'd6; vecs[3].va = 32'd4; vecs[3].rb = 5'd0; vecs[3].vb = 32'd0;
      vecs[3].cyc_fwd = 7; vecs[3].cyc_nofwd = 7; vecs[3].ret = 3;
      // MUL / SLT / SW with negative values
      vecs[4].prog[0] = enc_i(ADDI, 0, 1, -3); vecs[4].prog[1] = enc_i(ADDI, 0, 2, 6);
      vecs[4].prog[2] = enc_r(MUL, 1, 2, 3);   vecs[4].prog[3] = enc_r(SLT, 3, 0, 4);
      vecs[4].prog[4] = enc_i(SW, 0, 3, 50);   vecs[4].prog[5] = HLT; vecs[4].n = 6;
      vecs[4].ra = 5'd3; vecs[4].va = 32'hFFFFFFEE; vecs[4].rb = 5'd4; vecs[4].vb = 32'd1;
      vecs[4].cmv = 32'hFFFFFFEE;
      vecs[4].cyc_fwd = 10; vecs[4].cyc_nofwd = 14; vecs[4].ret = 6;
      // AND / OR / SUB / SLTI
      vecs[5].prog[0] = enc_i(ADDI, 0, 1, 12); vecs[5].prog[1] = enc_i(ADDI, 0, 2, 10);
      vecs[5].prog[2] = enc_r(AND_, 1, 2, 3);  vecs[5].prog[3] = enc_r(OR_, 1, 2, 4);
      vecs[5].prog[4] = enc_r(SUB, 3, 4, 5);   vecs[5].prog[5] = enc_i(SLTI, 5, 6, -5);
      vecs[5].prog[6] = HLT; vecs[5].n = 7;
      vecs[5].ra = 5'd5; vecs[5].va = 32'hFFFFFFFA; vecs[5].rb = 5'd6; vecs[5].vb = 32'd1;
      vecs[5].cyc_fwd = 11; vecs[5].cyc_nofwd = 17; vecs[5].ret = 7;
      // taken branch squashes HLT sitting in ID
      vecs[6].prog[0] = enc_i(BEQZ, 0, 0, 1); vecs[6].prog[1] = HLT;
      vecs[6].prog[2] = enc_i(ADDI, 0, 9, 9); vecs[6].prog[3] = HLT; vecs[6].n = 4;
      vecs[6].ra = 5'd9; vecs[6].va = 32'd9; vecs[6].rb = 5'd0; vecs[6].vb = 32'd0;
      vecs[6].cyc_fwd = 9; vecs[6].cyc_nofwd = 9; vecs[6].ret = 3;

      // ---- table loop ----
      for (int t = 0; t < 7; t++) begin
         enter_reset($sformatf("v%0d", t));
         clear_state();
         for (int k = 0; k < vecs[t].n; k++) dut.Mem[k] <= vecs[t].prog[k];
         dut.Reg[vecs[t].pre_r] <= vecs[t].pre_rv;
         dut.Mem[vecs[t].pre_m] <= vecs[t].pre_mv;
         run_to_halt($sformatf("v%0d", t), 200, cyc);
`ifdef MIPS32_FWD_EN
         exp_cyc = vecs[t].cyc_fwd;
`else
         exp_cyc = vecs[t].cyc_nofwd;
`endif
         check($sformatf("v%0d_cycles", t), cyc, exp_cyc);
         check($sformatf("v%0d_R%0d", t, vecs[t].ra), dut.Reg[vecs[t].ra], vecs[t].va);
         check($sformatf("v%0d_R%0d", t, vecs[t].rb), dut.Reg[vecs[t].rb], vecs[t].vb);
         check($sformatf("v%0d_Mem%0d", t, vecs[t].cm), dut.Mem[vecs[t].cm], vecs[t].cmv);
         check($sformatf("v%0d_retired", t), bus.retired, vecs[t].ret);
      end

      // ---- branch squash of two younger instructions ----
      enter_reset("sq");
      clear_state();
      hp = '{enc_i(BEQZ, 0, 0, 2), enc_i(ADDI, 0, 6, 1), enc_i(ADDI, 0, 7, 1),
             enc_i(ADDI, 0, 8, 3), HLT};
      load_hp();
      dut.Reg[6] <= 32'd55;
      dut.Reg[7] <= 32'd55;
      run_to_halt("sq", 200, cyc);
      check("sq_cycles", cyc, 32'd9);
      check("sq_R6", dut.Reg[6], 32'd55);
      check("sq_R7", dut.Reg[7], 32'd55);
      check("sq_R8", dut.Reg[8], 32'd3);
      check("sq_retired", bus.retired, 32'd3);

      // ---- factorial, then freeze after halt ----
      enter_reset("fact");
      clear_state();
      load_factorial();
      run_to_halt("fact", 1000, cyc);
      check("fact_Mem198", dut.Mem[198], 32'd5040);
      check("fact_R2", dut.Reg[2], 32'd5040);
      check("fact_retired", bus.retired, 32'd26);
      repeat (5) @(posedge clk);
      #1;
      check("frozen_halted", {31'd0, bus.halted}, 32'd1);
      check("frozen_pc", bus.pc_out, 32'd8);
      check("frozen_retired", bus.retired, 32'd26);

      // ---- reset in the middle of the loop, then rerun ----
      enter_reset("mid");
      clear_state();
      load_factorial();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_pc", bus.pc_out, 32'd0);
      check("mid_rst_halted", {31'd0, bus.halted}, 32'd0);
      check("mid_rst_retired", bus.retired, 32'd0);
      dut.Mem[198] <= 32'd0;
      run_to_halt("rerun", 1000, cyc);
      check("rerun_Mem198", dut.Mem[198], 32'd5040);
      check("rerun_R2", dut.Reg[2], 32'd5040);
      check("rerun_retired", bus.retired, 32'd26);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
